saturn_pc_rstk_gen: RTL and testbench

Parametrised program-counter and return-stack unit for the Saturn core, replacing the fixed 20-bit / 8-entry PC+RSTK block. It assembles nibble-serial jump offsets of any length up to MAX_NIBS, supports relative and absolute targets with optional push (GOSUB), RTN pop, and direct RSTK push/pop of data (C=RSTK / RSTK=C). It also implements true Saturn stack semantics: overflow discards the oldest entry, underflow returns zero, and an occupancy count is maintained. It sits between the decoder/bus controller and the fetch unit.

---
 rtl/saturn_pc_rstk_gen_if.sv | 49 ++++
 rtl/saturn_pc_rstk_gen.sv | 212 +++++++++++++++++++++
 tb/tb_saturn_pc_rstk_gen.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/saturn_pc_rstk_gen_if.sv
// Request/response bundle between the decoder/bus controller and the PC + return-stack unit.
// The decoder side drives requests (master); the PC/RSTK unit answers (slave).
interface saturn_pc_rstk_gen_if #(
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 8
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic              i_clk_en;
    logic              i_stall;
    logic              i_pc_inc;
    logic              i_jump_start;
    logic [2:0]        i_jump_len;
    logic              i_jump_rel;
    logic              i_jump_push;
    logic [3:0]        i_nibble;
    logic              i_nibble_valid;
    logic              i_rtn;
    logic              i_push_data;
    logic              i_pop_data;
    logic [ADDR_W-1:0] i_data;
    logic [IDX_W-1:0]  i_dbg_idx;

    logic [ADDR_W-1:0] o_pc;
    logic              o_busy;
    logic              o_jump_done;
    logic [ADDR_W-1:0] o_pop_val;
    logic [CNT_W-1:0]  o_rstk_count;
    logic              o_overflow;
    logic              o_underflow;
    logic [ADDR_W-1:0] o_dbg_val;

    modport master (
        output i_clk_en, i_stall, i_pc_inc, i_jump_start, i_jump_len, i_jump_rel,
               i_jump_push, i_nibble, i_nibble_valid, i_rtn, i_push_data, i_pop_data,
               i_data, i_dbg_idx,
        input  o_pc, o_busy, o_jump_done, o_pop_val, o_rstk_count, o_overflow,
               o_underflow, o_dbg_val
    );

    modport slave (
        input  i_clk_en, i_stall, i_pc_inc, i_jump_start, i_jump_len, i_jump_rel,
               i_jump_push, i_nibble, i_nibble_valid, i_rtn, i_push_data, i_pop_data,
               i_data, i_dbg_idx,
        output o_pc, o_busy, o_jump_done, o_pop_val, o_rstk_count, o_overflow,
               o_underflow, o_dbg_val
    );
endinterface

// File: rtl/saturn_pc_rstk_gen.sv
// Saturn PC + return stack: nibble-serial jump decode, GOSUB/RTN, data push/pop; results land one edge after the request.
// No backpressure out; i_clk_en=0 or i_stall=1 freezes all state except the post-reset INIT clear.
module saturn_pc_rstk_gen #(
    parameter int ADDR_W   = 20,
    parameter int DEPTH    = 8,
    parameter int MAX_NIBS = 5
) (
    input logic                 i_clk,
    input logic                 i_reset_n,
    saturn_pc_rstk_gen_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_DECODE} state_t;

    state_t           state, state_n;
    addr_t            pc, pc_n;
    addr_t            base, base_n;
    addr_t            off, off_n;
    addr_t            pop_val, pop_val_n;
    logic [2:0]       len, len_n;
    logic [2:0]       k, k_n;
    logic             rel, rel_n;
    logic             push, push_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic [PTR_W-1:0] init_idx, init_idx_n;
    logic [CNT_W-1:0] count, count_n;
    logic             jump_done, jump_done_n;
    logic             ovf, ovf_n;
    logic             udf, udf_n;

    addr_t            mem [DEPTH];
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    addr_t            mem_wdat;

    logic             push_req, pop_req;
    addr_t            push_dat;
    logic             en, last, sign, len_ok, empty, full;
    addr_t            off_nxt, mask, target, top_val;

    assign en      = bus.i_clk_en & ~bus.i_stall;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign top_val = empty ? '0 : mem[ptr];
    assign len_ok  = (bus.i_jump_len != 3'd0) && ({1'b0, bus.i_jump_len} <= 4'(MAX_NIBS));

    // Offset as it will be once this cycle's nibble is merged; the target is built from it.
    assign off_nxt = off | (addr_t'(bus.i_nibble) << {k, 2'b00});
    assign mask    = ~({ADDR_W{1'b1}} << {len, 2'b00});
    assign sign    = |(off_nxt & (mask ^ (mask >> 1)));
    assign target  = rel ? (base + (off_nxt | (sign ? ~mask : '0))) : off_nxt;
    assign last    = bus.i_nibble_valid && ((k + 3'd1) == len);

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        base_n      = base;
        off_n       = off;
        pop_val_n   = pop_val;
        len_n       = len;
        k_n         = k;
        rel_n       = rel;
        push_n      = push;
        ptr_n       = ptr;
        init_idx_n  = init_idx;
        count_n     = count;
        jump_done_n = 1'b0;
        ovf_n       = ovf;
        udf_n       = udf;
        mem_we      = 1'b0;
        mem_waddr   = ptr;
        mem_wdat    = '0;
        push_req    = 1'b0;
        pop_req     = 1'b0;
        push_dat    = '0;

        unique case (state)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_idx;
                init_idx_n = init_idx + 1'b1;
                if (init_idx == PTR_W'(DEPTH - 1))
                    state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (en) begin
                    if (bus.i_rtn) begin
                        pop_req     = 1'b1;
                        pc_n        = top_val;
                        pop_val_n   = top_val;
                        jump_done_n = 1'b1;
                    end else begin
                        if (bus.i_pc_inc)
                            pc_n = pc + 1'b1;
                        if (bus.i_pop_data) begin
                            pop_req   = 1'b1;
                            pop_val_n = top_val;
                        end else if (bus.i_push_data) begin
                            push_req = 1'b1;
                            push_dat = bus.i_data;
                        end
                    end
                    if (bus.i_jump_start && len_ok) begin
                        len_n   = bus.i_jump_len;
                        rel_n   = bus.i_jump_rel;
                        push_n  = bus.i_jump_push;
                        base_n  = pc;
                        k_n     = 3'd0;
                        off_n   = '0;
                        state_n = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                if (en) begin
                    if (bus.i_pc_inc)
                        pc_n = pc + 1'b1;
                    if (bus.i_nibble_valid) begin
                        off_n = off_nxt;
                        k_n   = k + 3'd1;
                    end
                    if (last) begin
                        pc_n        = target;
                        push_req    = push;
                        push_dat    = pc;
                        jump_done_n = 1'b1;
                        state_n     = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_INIT;
        endcase

        // Popped slots are zeroed so debug reads below the top show empty entries as 0.
        if (pop_req) begin
            if (empty) begin
                udf_n = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = ptr;
                mem_wdat  = '0;
                ptr_n     = ptr - 1'b1;
                count_n   = count - 1'b1;
            end
        end

        // A full stack wraps onto the oldest slot, which is exactly the one ptr+1 lands on.
        if (push_req) begin
            ptr_n     = ptr + 1'b1;
            mem_we    = 1'b1;
            mem_waddr = ptr + 1'b1;
            mem_wdat  = push_dat;
            if (full)
                ovf_n = 1'b1;
            else
                count_n = count + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_INIT;
            pc        <= '0;
            base      <= '0;
            off       <= '0;
            pop_val   <= '0;
            len       <= 3'd0;
            k         <= 3'd0;
            rel       <= 1'b0;
            push      <= 1'b0;
            ptr       <= PTR_W'(DEPTH - 1);
            init_idx  <= '0;
            count     <= '0;
            jump_done <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            base      <= base_n;
            off       <= off_n;
            pop_val   <= pop_val_n;
            len       <= len_n;
            k         <= k_n;
            rel       <= rel_n;
            push      <= push_n;
            ptr       <= ptr_n;
            init_idx  <= init_idx_n;
            count     <= count_n;
            jump_done <= jump_done_n;
            ovf       <= ovf_n;
            udf       <= udf_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdat;
    end

    assign bus.o_pc         = pc;
    assign bus.o_busy       = (state != ST_IDLE);
    assign bus.o_jump_done  = jump_done;
    assign bus.o_pop_val    = pop_val;
    assign bus.o_rstk_count = count;
    assign bus.o_overflow   = ovf;
    assign bus.o_underflow  = udf;
    assign bus.o_dbg_val    = mem[ptr - bus.i_dbg_idx];
endmodule

// File: tb/tb_saturn_pc_rstk_gen.sv
// Bench for saturn_pc_rstk_gen: directed scenarios plus randomized traffic against a queue-based stack/PC model.
module tb_saturn_pc_rstk_gen;
    localparam int AW = 20;
    localparam int D  = 8;
    localparam int MN = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    saturn_pc_rstk_gen_if #(.ADDR_W(AW), .DEPTH(D)) bus ();
    saturn_pc_rstk_gen #(.ADDR_W(AW), .DEPTH(D), .MAX_NIBS(MN)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_pop_val;
    logic [AW-1:0] m_stk[$];   // oldest at front, top at back
    bit            m_ovf, m_udf;

    function automatic void m_reset();
        m_pc = '0; m_pop_val = '0; m_stk.delete(); m_ovf = 0; m_udf = 0;
    endfunction

    function automatic void m_push(input logic [AW-1:0] v);
        if (m_stk.size() == D) begin
            void'(m_stk.pop_front());
            m_ovf = 1;
        end
        m_stk.push_back(v);
    endfunction

    function automatic logic [AW-1:0] m_pop();
        if (m_stk.size() == 0) begin
            m_udf = 1;
            return '0;
        end
        return m_stk.pop_back();
    endfunction

    function automatic logic [AW-1:0] m_dbg(input int i);
        if (i < m_stk.size()) return m_stk[m_stk.size() - 1 - i];
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_clk_en = 1; bus.i_stall = 0; bus.i_pc_inc = 0; bus.i_jump_start = 0;
        bus.i_jump_len = 0; bus.i_jump_rel = 0; bus.i_jump_push = 0; bus.i_nibble = 0;
        bus.i_nibble_valid = 0; bus.i_rtn = 0; bus.i_push_data = 0; bus.i_pop_data = 0;
        bus.i_data = 0; bus.i_dbg_idx = 0;
    endtask

    // Drives a full jump and updates the model; noisy mode inserts ignored/frozen cycles.
    task automatic run_jump(input logic [2:0] len, input logic rel, input logic push,
                            input logic [AW-1:0] off, input logic [4:0] inc_mask,
                            input bit noisy, output logic done_seen);
        logic [AW-1:0] base, pre;
        longint so;
        int L, gaps;
        L = int'(len);
        bus.i_jump_start = 1; bus.i_jump_len = len; bus.i_jump_rel = rel; bus.i_jump_push = push;
        tick();
        bus.i_jump_start = 0;
        base = m_pc;
        for (int i = 0; i < L; i++) begin
            if (noisy) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    bus.i_nibble_valid = 1'($urandom);
                    bus.i_nibble = 4'($urandom);
                    bus.i_stall = 1'($urandom);
                    bus.i_clk_en = (bus.i_nibble_valid && !bus.i_stall) ? 1'b0 : 1'b1;
                    bus.i_pc_inc = 1'($urandom);
                    bus.i_rtn = 1'($urandom);
                    bus.i_push_data = 1'($urandom);
                    bus.i_pop_data = 1'($urandom);
                    bus.i_data = AW'($urandom);
                    tick();
                    if (bus.i_clk_en && !bus.i_stall && bus.i_pc_inc) m_pc = m_pc + 1;
                end
            end
            bus.i_stall = 0; bus.i_clk_en = 1; bus.i_rtn = 0; bus.i_push_data = 0; bus.i_pop_data = 0;
            bus.i_nibble_valid = 1; bus.i_nibble = off[4*i +: 4]; bus.i_pc_inc = inc_mask[i];
            tick();
            if (i < L - 1 && inc_mask[i]) m_pc = m_pc + 1;
        end
        done_seen = bus.o_jump_done;
        idle_inputs();
        pre = m_pc;
        if (rel) begin
            so = longint'(off);
            if (so >= (64'sd1 <<< (4*L - 1))) so = so - (64'sd1 <<< (4*L));
            m_pc = AW'(longint'(base) + so);
        end else begin
            m_pc = off;
        end
        if (push) m_push(pre);
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rst_n = 0;
        bus.i_push_data = 1; bus.i_pc_inc = 1; bus.i_jump_start = 1; bus.i_jump_len = 1;
        #13;
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", bus.o_busy); end
        checks++; if (bus.o_pc !== '0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.o_pc); end
        checks++; if (bus.o_rstk_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.o_rstk_count); end
        checks++; if (bus.o_jump_done !== 1'b0 || bus.o_pop_val !== '0) begin errors++; $display("FAIL reset_done_popval: got %b/%h expected 0/0", bus.o_jump_done, bus.o_pop_val); end
        checks++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", bus.o_overflow, bus.o_underflow); end
        @(posedge clk); #1;
        rst_n = 1;
        n = 0;
        while (bus.o_busy && n < 20) begin
            tick();
            n++;
        end
        idle_inputs();
        m_reset();
        checks++; if (n != D) begin errors++; $display("FAIL init_length: got %0d cycles expected %0d", n, D); end
        checks++; if (bus.o_pc !== '0 || bus.o_rstk_count !== '0) begin errors++; $display("FAIL init_ignores_reqs: got pc=%h cnt=%0d expected 0/0", bus.o_pc, bus.o_rstk_count); end
        for (int i = 0; i < D; i++) begin
            bus.i_dbg_idx = 3'(i);
            #1;
            checks++; if (bus.o_dbg_val !== '0) begin errors++; $display("FAIL init_dbg[%0d]: got %h expected 0", i, bus.o_dbg_val); end
        end
        bus.i_dbg_idx = 0;
    endtask

    task automatic test_rel_goto();
        logic d;
        run_jump(3'd3, 1'b0, 1'b0, 20'h00100, 5'b0, 1'b0, d);
        checks++; if (bus.o_pc !== 20'h00100) begin errors++; $display("FAIL abs_setup_pc: got %h expected 00100", bus.o_pc); end
        tick();
        run_jump(3'd3, 1'b1, 1'b0, 20'h00FFF, 5'b00111, 1'b0, d);
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL rel_goto_done: got %b expected 1", d); end
        checks++; if (bus.o_pc !== 20'h000FF || bus.o_pc !== m_pc) begin errors++; $display("FAIL rel_goto_pc: got %h expected 000ff (model %h)", bus.o_pc, m_pc); end
        checks++; if (bus.o_rstk_count !== '0) begin errors++; $display("FAIL rel_goto_count: got %0d expected 0", bus.o_rstk_count); end
        tick();
        checks++; if (bus.o_jump_done !== 1'b0) begin errors++; $display("FAIL rel_goto_pulse: got %b expected 0", bus.o_jump_done); end
    endtask

    task automatic test_gosub_rtn();
        logic d;
        logic [AW-1:0] v;
        run_jump(3'd3, 1'b0, 1'b0, 20'h00200, 5'b0, 1'b0, d);
        run_jump(3'd5, 1'b0, 1'b1, 20'h12345, 5'b00111, 1'b0, d);
        bus.i_dbg_idx = 0;
        #1;
        checks++; if (d !== 1'b1 || bus.o_pc !== 20'h12345) begin errors++; $display("FAIL gosub_pc: got %h done=%b expected 12345 done=1", bus.o_pc, d); end
        checks++; if (bus.o_rstk_count !== 4'd1 || bus.o_dbg_val !== 20'h00203) begin errors++; $display("FAIL gosub_push: got cnt=%0d top=%h expected 1/00203", bus.o_rstk_count, bus.o_dbg_val); end
        bus.i_rtn = 1; bus.i_pc_inc = 1;
        tick();
        idle_inputs();
        v = m_pop(); m_pc = v; m_pop_val = v;
        checks++; if (bus.o_pc !== 20'h00203 || bus.o_jump_done !== 1'b1) begin errors++; $display("FAIL rtn_pc: got %h done=%b expected 00203 done=1", bus.o_pc, bus.o_jump_done); end
        checks++; if (bus.o_rstk_count !== '0 || bus.o_pop_val !== 20'h00203) begin errors++; $display("FAIL rtn_pop: got cnt=%0d val=%h expected 0/00203", bus.o_rstk_count, bus.o_pop_val); end
    endtask

    task automatic test_overflow();
        for (int v = 1; v <= 9; v++) begin
            bus.i_push_data = 1; bus.i_data = AW'(v);
            tick();
            m_push(AW'(v));
        end
        idle_inputs();
        checks++; if (bus.o_rstk_count !== 4'd8 || bus.o_overflow !== 1'b1 || bus.o_underflow !== 1'b0) begin errors++; $display("FAIL ovf_state: got cnt=%0d ovf=%b udf=%b expected 8/1/0", bus.o_rstk_count, bus.o_overflow, bus.o_underflow); end
        for (int i = 0; i < D; i++) begin
            bus.i_dbg_idx = 3'(i);
            #1;
            checks++; if (bus.o_dbg_val !== AW'(9 - i)) begin errors++; $display("FAIL ovf_dbg[%0d]: got %h expected %h", i, bus.o_dbg_val, AW'(9 - i)); end
        end
        bus.i_dbg_idx = 0;
        for (int i = 0; i < 9; i++) begin
            bus.i_pop_data = 1;
            tick();
            m_pop_val = m_pop();
            bus.i_pop_data = 0;
            checks++; if (bus.o_pop_val !== ((i < 8) ? AW'(9 - i) : AW'(0))) begin errors++; $display("FAIL pop_val[%0d]: got %h expected %h", i, bus.o_pop_val, (i < 8) ? AW'(9 - i) : AW'(0)); end
        end
        checks++; if (bus.o_underflow !== 1'b1 || bus.o_rstk_count !== '0) begin errors++; $display("FAIL udf_state: got udf=%b cnt=%0d expected 1/0", bus.o_underflow, bus.o_rstk_count); end
        checks++; if (bus.o_pc !== m_pc || bus.o_jump_done !== 1'b0) begin errors++; $display("FAIL pop_keeps_pc: got %h done=%b expected %h done=0", bus.o_pc, bus.o_jump_done, m_pc); end
    endtask

    task automatic test_wrap();
        logic d;
        run_jump(3'd5, 1'b0, 1'b0, 20'hFFFFE, 5'b0, 1'b0, d);
        run_jump(3'd2, 1'b1, 1'b0, 20'h00004, 5'b0, 1'b0, d);
        checks++; if (bus.o_pc !== 20'h00002 || d !== 1'b1) begin errors++; $display("FAIL wrap_pc: got %h done=%b expected 00002 done=1", bus.o_pc, d); end
    endtask

    task automatic test_stall_reset();
        logic [AW-1:0] pc0;
        bit saw_done;
        bus.i_jump_start = 1; bus.i_jump_len = 3'd3; bus.i_jump_rel = 0;
        tick();
        bus.i_jump_start = 0;
        bus.i_nibble_valid = 1; bus.i_nibble = 4'h7;
        tick();
        pc0 = bus.o_pc;
        for (int c = 0; c < 12; c++) begin
            bus.i_stall = (c < 6); bus.i_clk_en = (c >= 6) ? 1'b0 : 1'b1;
            bus.i_nibble_valid = c[0]; bus.i_nibble = 4'($urandom); bus.i_pc_inc = 1;
            tick();
            checks++; if (bus.o_pc !== pc0 || bus.o_busy !== 1'b1 || bus.o_jump_done !== 1'b0) begin errors++; $display("FAIL frozen[%0d]: got pc=%h busy=%b done=%b expected %h/1/0", c, bus.o_pc, bus.o_busy, bus.o_jump_done, pc0); end
        end
        bus.i_stall = 0; bus.i_clk_en = 1; bus.i_pc_inc = 0; bus.i_nibble_valid = 1;
        tick();
        checks++; if (bus.o_busy !== 1'b1 || bus.o_jump_done !== 1'b0) begin errors++; $display("FAIL second_nibble: got busy=%b done=%b expected 1/0", bus.o_busy, bus.o_jump_done); end
        rst_n = 0;
        #1;
        checks++; if (bus.o_pc !== '0 || bus.o_busy !== 1'b1) begin errors++; $display("FAIL reset_mid_decode: got pc=%h busy=%b expected 0/1", bus.o_pc, bus.o_busy); end
        tick();
        rst_n = 1;
        saw_done = 0;
        for (int c = 0; c < 14; c++) begin
            bus.i_nibble_valid = 1'($urandom);
            tick();
            if (bus.o_jump_done) saw_done = 1;
        end
        idle_inputs();
        m_reset();
        checks++; if (saw_done) begin errors++; $display("FAIL aborted_jump: got done=1 expected no completion"); end
        checks++; if (bus.o_pc !== '0 || bus.o_busy !== 1'b0 || bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0) begin errors++; $display("FAIL after_reset: got pc=%h busy=%b flags=%b%b expected 0/0/00", bus.o_pc, bus.o_busy, bus.o_overflow, bus.o_underflow); end
    endtask

    task automatic test_random_stack();
        logic [AW-1:0] v;
        bit fire, mdone;
        int idx;
        for (int c = 0; c < 300; c++) begin
            bus.i_rtn = ($urandom_range(0, 5) == 0);
            bus.i_pop_data = ($urandom_range(0, 4) == 0);
            bus.i_push_data = 1'($urandom);
            bus.i_pc_inc = ($urandom_range(0, 2) == 0);
            bus.i_clk_en = ($urandom_range(0, 7) != 0);
            bus.i_stall = ($urandom_range(0, 7) == 0);
            bus.i_data = AW'($urandom);
            idx = $urandom_range(0, D - 1);
            bus.i_dbg_idx = 3'(idx);
            fire = bus.i_clk_en && !bus.i_stall;
            mdone = 0;
            if (fire) begin
                if (bus.i_rtn) begin
                    v = m_pop(); m_pc = v; m_pop_val = v; mdone = 1;
                end else begin
                    if (bus.i_pc_inc) m_pc = m_pc + 1;
                    if (bus.i_pop_data) m_pop_val = m_pop();
                    else if (bus.i_push_data) m_push(bus.i_data);
                end
            end
            tick();
            checks++; if (bus.o_pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", c, bus.o_pc, m_pc); end
            checks++; if (bus.o_rstk_count !== 4'(m_stk.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, bus.o_rstk_count, m_stk.size()); end
            checks++; if (bus.o_pop_val !== m_pop_val) begin errors++; $display("FAIL rnd_popval[%0d]: got %h expected %h", c, bus.o_pop_val, m_pop_val); end
            checks++; if (bus.o_jump_done !== mdone) begin errors++; $display("FAIL rnd_done[%0d]: got %b expected %b", c, bus.o_jump_done, mdone); end
            checks++; if (bus.o_overflow !== m_ovf || bus.o_underflow !== m_udf) begin errors++; $display("FAIL rnd_flags[%0d]: got %b%b expected %b%b", c, bus.o_overflow, bus.o_underflow, m_ovf, m_udf); end
            checks++; if (bus.o_dbg_val !== m_dbg(idx)) begin errors++; $display("FAIL rnd_dbg[%0d] idx %0d: got %h expected %h", c, idx, bus.o_dbg_val, m_dbg(idx)); end
        end
        idle_inputs();
    endtask

    task automatic test_random_jumps();
        logic d;
        logic [2:0] len;
        logic [AW-1:0] off;
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0:       len = 3'd0;
                    1:       len = 3'd6;
                    default: len = 3'd7;
                endcase
                bus.i_jump_start = 1; bus.i_jump_len = len;
                tick();
                idle_inputs();
                checks++; if (bus.o_busy !== 1'b0 || bus.o_pc !== m_pc) begin errors++; $display("FAIL bad_len %0d: got busy=%b pc=%h expected 0/%h", len, bus.o_busy, bus.o_pc, m_pc); end
            end else begin
                len = 3'($urandom_range(1, MN));
                off = AW'($urandom) & AW'((64'd1 << (4 * int'(len))) - 1);
                run_jump(len, 1'($urandom), 1'($urandom), off, 5'($urandom), 1'b1, d);
                bus.i_dbg_idx = 0;
                #1;
                checks++; if (d !== 1'b1 || bus.o_pc !== m_pc) begin errors++; $display("FAIL rnd_jump[%0d] len %0d: got pc=%h done=%b expected %h done=1", j, len, bus.o_pc, d, m_pc); end
                checks++; if (bus.o_rstk_count !== 4'(m_stk.size()) || bus.o_dbg_val !== m_dbg(0)) begin errors++; $display("FAIL rnd_jump_stack[%0d]: got cnt=%0d top=%h expected %0d/%h", j, bus.o_rstk_count, bus.o_dbg_val, m_stk.size(), m_dbg(0)); end
                tick();
                checks++; if (bus.o_jump_done !== 1'b0) begin errors++; $display("FAIL rnd_jump_pulse[%0d]: got 1 expected 0", j); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        test_reset();
        test_rel_goto();
        test_gosub_rtn();
        test_overflow();
        test_wrap();
        test_stall_reset();
        test_random_stack();
        test_random_jumps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
